// File: rtl/otp_ctrl_lci_seq_if.sv
// Handshake bundle between the life cycle programming sequencer, the LC controller
// and the OTP macro arbiter.
//   master : sequencer side (drives lc_ack/lc_err and the otp_* request fields)
//   slave  : environment side (drives lc_req/lc_data and the otp_* response fields)
// Signals:
//   lc_req / lc_data           transition request and image (word i at [i*WordWidth +: WordWidth])
//   lc_ack / lc_err            one-cycle done pulse, qualified by aggregated failure
//   otp_req/cmd/addr/wdata     macro request (cmd 0 = Read, 1 = Write), held until otp_gnt
//   otp_gnt                    request accepted
//   otp_rvalid/rdata/err       macro response (err 0 = NoError)
interface otp_ctrl_lci_seq_if #(
    parameter int unsigned NumWords  = 10,
    parameter int unsigned WordWidth = 16,
    parameter int unsigned AddrWidth = 11
);
    logic                            lc_req;
    logic [NumWords*WordWidth-1:0]   lc_data;
    logic                            lc_ack;
    logic                            lc_err;
    logic                            otp_req;
    logic                            otp_cmd;
    logic [AddrWidth-1:0]            otp_addr;
    logic [WordWidth-1:0]            otp_wdata;
    logic                            otp_gnt;
    logic                            otp_rvalid;
    logic [WordWidth-1:0]            otp_rdata;
    logic [2:0]                      otp_err;

    modport master (
        input  lc_req, lc_data, otp_gnt, otp_rvalid, otp_rdata, otp_err,
        output lc_ack, lc_err, otp_req, otp_cmd, otp_addr, otp_wdata
    );

    modport slave (
        output lc_req, lc_data, otp_gnt, otp_rvalid, otp_rdata, otp_err,
        input  lc_ack, lc_err, otp_req, otp_cmd, otp_addr, otp_wdata
    );
endinterface

// File: rtl/otp_ctrl_lci_seq.sv
// Life cycle programming sequencer: burns NumWords native words of an LC image starting at
// BaseAddr. Zero words are skipped, MacroError responses are retried up to MaxRetries times per
// word, and failures are aggregated (remaining words are still programmed).
// Optional feature macro: OTP_LCI_READBACK_EN adds a read-back compare after every successful
// write; a mismatch (or read error) counts as CheckFailError and is retried like MacroError.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   lci_en_i          enable, leaves ResetSt
//   escalate_i        escalation, forces terminal ErrorSt
//   bus (master)      LC request/ack and OTP macro request/response bundle
//   error_o           latched error code (otp_err_e encoding)
//   fsm_err_o         pulse on illegal state, counter fault or escalation
//   idle_o            high only in IdleSt
module otp_ctrl_lci_seq #(
    parameter int unsigned NumWords   = 10,
    parameter int unsigned WordWidth  = 16,
    parameter int unsigned AddrWidth  = 11,
    parameter int unsigned BaseAddr   = 'h170,
    parameter int unsigned MaxRetries = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                lci_en_i,
    input  logic                escalate_i,
    otp_ctrl_lci_seq_if.master  bus,
    output logic [2:0]          error_o,
    output logic                fsm_err_o,
    output logic                idle_o
);

    localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

    localparam logic [2:0] NoError        = 3'd0;
    localparam logic [2:0] MacroError     = 3'd1;
    localparam logic [2:0] CheckFailError = 3'd6;
    localparam logic [2:0] FsmStateError  = 3'd7;

    // Codewords of the [8,4,4] Reed-Muller code: pairwise Hamming distance >= 4.
    typedef enum logic [7:0] {
        ResetSt     = 8'b0011_1100,
        IdleSt      = 8'b1111_0000,
        WriteSt     = 8'b1100_1100,
        WriteWaitSt = 8'b1010_1010,
        ReadSt      = 8'b0101_1010,
        ReadWaitSt  = 8'b0110_0110,
        ErrorSt     = 8'b0000_1111
    } state_e;

    state_e           state_d, state_q;
    logic [IdxW-1:0]  idx_d, idx_q, idx_inv_q;
    logic [2:0]       retry_d, retry_q;
    logic [2:0]       error_d, error_q;
    logic [WordWidth-1:0] cur_word;
    logic             cnt_err, retry_ok, word_done;

    // Word counter is stored twice (true and inverted); any disagreement is a fault.
    assign cnt_err  = (idx_q != ~idx_inv_q) || (idx_q > LastIdx);
    assign cur_word = bus.lc_data[WordWidth*idx_q +: WordWidth];
    assign retry_ok = 32'(retry_q) < MaxRetries;
    assign error_o  = error_q;
    assign idle_o   = (state_q == IdleSt);

`ifndef OTP_LCI_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^bus.otp_rdata;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        error_d       = error_q;
        word_done     = 1'b0;
        fsm_err_o     = 1'b0;
        bus.lc_ack    = 1'b0;
        bus.lc_err    = 1'b0;
        bus.otp_req   = 1'b0;
        bus.otp_cmd   = 1'b0;
        bus.otp_addr  = '0;
        bus.otp_wdata = '0;

        case (state_q)
            ResetSt: begin
                if (lci_en_i) state_d = IdleSt;
            end
            IdleSt: begin
                if (bus.lc_req) begin
                    state_d = WriteSt;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            WriteSt: begin
                if (cur_word == '0) begin
                    word_done = 1'b1;
                end else begin
                    bus.otp_req   = 1'b1;
                    bus.otp_cmd   = 1'b1;
                    bus.otp_addr  = AddrWidth'(BaseAddr) + AddrWidth'(idx_q);
                    bus.otp_wdata = cur_word;
                    if (bus.otp_gnt) state_d = WriteWaitSt;
                end
            end
            WriteWaitSt: begin
                if (bus.otp_rvalid) begin
                    if (bus.otp_err == MacroError && retry_ok) begin
                        retry_d = retry_q + 3'd1;
                        state_d = WriteSt;
                    end else if (bus.otp_err != NoError) begin
                        if (error_q == NoError) error_d = bus.otp_err;
                        word_done = 1'b1;
                    end else begin
`ifdef OTP_LCI_READBACK_EN
                        state_d = ReadSt;
`else
                        word_done = 1'b1;
`endif
                    end
                end
            end
`ifdef OTP_LCI_READBACK_EN
            ReadSt: begin
                bus.otp_req  = 1'b1;
                bus.otp_addr = AddrWidth'(BaseAddr) + AddrWidth'(idx_q);
                if (bus.otp_gnt) state_d = ReadWaitSt;
            end
            ReadWaitSt: begin
                if (bus.otp_rvalid) begin
                    if (bus.otp_rdata == cur_word && bus.otp_err == NoError) begin
                        word_done = 1'b1;
                    end else if (retry_ok) begin
                        retry_d = retry_q + 3'd1;
                        state_d = WriteSt;
                    end else begin
                        if (error_q == NoError) error_d = CheckFailError;
                        word_done = 1'b1;
                    end
                end
            end
`endif
            ErrorSt: begin
                if (error_q == NoError) error_d = FsmStateError;
            end
            default: begin
                state_d   = ErrorSt;
                fsm_err_o = 1'b1;
                if (error_q == NoError) error_d = FsmStateError;
            end
        endcase

        if (word_done) begin
            if (idx_q == LastIdx) begin
                bus.lc_ack = 1'b1;
                bus.lc_err = (error_d != NoError);
                state_d    = (error_d != NoError) ? ErrorSt : IdleSt;
            end else begin
                idx_d   = idx_q + IdxW'(1);
                retry_d = '0;
                state_d = WriteSt;
            end
        end

        // Escalation and counter faults override every other transition.
        if (escalate_i || cnt_err) begin
            state_d    = ErrorSt;
            fsm_err_o  = 1'b1;
            bus.lc_ack = 1'b0;
            bus.lc_err = 1'b0;
            if (error_d == NoError) error_d = FsmStateError;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetSt;
            idx_q     <= '0;
            idx_inv_q <= '1;
            retry_q   <= '0;
            error_q   <= NoError;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            idx_inv_q <= ~idx_d;
            retry_q   <= retry_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_otp_ctrl_lci_seq.sv
// Self-checking bench for otp_ctrl_lci_seq: directed scenarios plus randomized images and
// macro response codes, compared against a word-by-word behavioural model.
module tb_otp_ctrl_lci_seq;
    localparam int unsigned NW   = 4;
    localparam int unsigned WW   = 16;
    localparam int unsigned AW   = 11;
    localparam int unsigned BASE = 'h170;
    localparam int unsigned MAXR = 2;

    typedef logic [AW+WW:0] txn_t;  // {cmd, addr, wdata}

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       lci_en = 1'b0;
    logic       escalate = 1'b0;
    logic [2:0] error_o;
    logic       fsm_err_o, idle_o;

    otp_ctrl_lci_seq_if #(.NumWords(NW), .WordWidth(WW), .AddrWidth(AW)) bus ();

    otp_ctrl_lci_seq #(
        .NumWords(NW), .WordWidth(WW), .AddrWidth(AW), .BaseAddr(BASE), .MaxRetries(MAXR)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lci_en_i(lci_en), .escalate_i(escalate),
        .bus(bus), .error_o(error_o), .fsm_err_o(fsm_err_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] img [NW];
    int          plan[$];
    int          codes_q[$];
    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [2:0]  exp_err;
    int          ack_cnt = 0;
    logic        last_ack_err = 1'b0;
    bit          resp_busy = 1'b0;
    int          hold = 0;
    bit          force_zero = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Macro responder: random grant latency, response code taken from codes_q per write.
    initial begin : responder
        int dly;
        int code;
        logic [15:0] last_wd;
        bus.otp_gnt = 1'b0; bus.otp_rvalid = 1'b0; bus.otp_rdata = '0; bus.otp_err = '0;
        last_wd = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.otp_req) begin
                resp_busy = 1'b1;
                dly = $urandom_range(0, 2);
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk_i);
                    chk("req_held", bus.otp_req, 1);
                end
                obs_q.push_back({bus.otp_cmd, bus.otp_addr, bus.otp_wdata});
                if (bus.otp_cmd) last_wd = bus.otp_wdata;
                code = 0;
                if (bus.otp_cmd && codes_q.size() > 0) code = codes_q.pop_front();
                bus.otp_gnt = 1'b1;
                @(negedge clk_i);
                bus.otp_gnt = 1'b0;
                dly = $urandom_range(0, 1) + hold;
                for (int i = 0; i < dly; i++) @(negedge clk_i);
                bus.otp_rvalid = 1'b1;
                bus.otp_err    = 3'(code);
                bus.otp_rdata  = force_zero ? 16'h0 : last_wd;
                @(negedge clk_i);
                bus.otp_rvalid = 1'b0; bus.otp_err = '0; bus.otp_rdata = '0;
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : ack_monitor
        forever begin
            @(negedge clk_i);
            #2;
            if (bus.lc_ack === 1'b1) begin
                ack_cnt++;
                last_ack_err = bus.lc_err;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Reference: walk the image word by word, consuming one planned code per write attempt.
    task automatic model_run();
        int ci; int retry; int c; bit done; logic [15:0] d;
        ci = 0; exp_q.delete(); exp_err = '0;
        for (int w = 0; w < int'(NW); w++) begin
            d = img[w];
            if (d != 16'h0) begin
                retry = 0; done = 1'b0;
                while (!done) begin
                    c = (ci < plan.size()) ? plan[ci] : 0;
                    ci++;
                    exp_q.push_back({1'b1, AW'(BASE + w), d});
                    if (c == 1 && retry < int'(MAXR)) retry++;
                    else if (c != 0) begin
                        if (exp_err == 0) exp_err = 3'(c);
                        done = 1'b1;
                    end else begin
`ifdef OTP_LCI_READBACK_EN
                        exp_q.push_back({1'b0, AW'(BASE + w), 16'h0});
                        if (!force_zero) done = 1'b1;
                        else if (retry < int'(MAXR)) retry++;
                        else begin
                            if (exp_err == 0) exp_err = 3'd6;
                            done = 1'b1;
                        end
`else
                        done = 1'b1;
`endif
                    end
                end
            end
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < int'(NW); i++) bus.lc_data[i*WW +: WW] = img[i];
    endtask

    task automatic do_reset();
        int n = 0;
        while (resp_busy && n < 100) begin @(negedge clk_i); n++; end
        chk("resp_idle_before_reset", resp_busy, 0);
        rst_ni = 1'b0; lci_en = 1'b0; escalate = 1'b0; bus.lc_req = 1'b0;
        hold = 0; force_zero = 1'b0;
        codes_q.delete(); obs_q.delete(); plan.delete();
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_outs", {bus.lc_ack, bus.lc_err, fsm_err_o, idle_o, bus.otp_req,
                           bus.otp_cmd, error_o}, 0);
        chk("reset_addr_wdata", {bus.otp_addr, bus.otp_wdata}, 0);
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i); #1 chk("resetst_not_idle", idle_o, 0);
        lci_en = 1'b1;
        @(negedge clk_i); #1 chk("idle_after_en", idle_o, 1);
    endtask

    task automatic run_txn(input string tag);
        int start; bit got;
        start = ack_cnt; got = 1'b0;
        codes_q = plan;
        model_run();
        load_image();
        bus.lc_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            #3;
            if (ack_cnt != start) begin got = 1'b1; break; end
        end
        bus.lc_req = 1'b0;
        chk({tag, "_ack_seen"}, got, 1);
        chk({tag, "_lc_err"}, last_ack_err, exp_err != 0);
        @(negedge clk_i); #1;
        chk({tag, "_error_o"}, error_o, exp_err);
        chk({tag, "_idle_o"}, idle_o, exp_err == 0);
        chk({tag, "_txn_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_txn"}, obs_q[i], exp_q[i]);
    endtask

    task automatic chk_locked(input string tag);
        bit seen; int a0;
        seen = 1'b0; a0 = ack_cnt;
        bus.lc_req = 1'b1;
        repeat (8) begin @(negedge clk_i); #1; if (bus.otp_req) seen = 1'b1; end
        bus.lc_req = 1'b0;
        chk({tag, "_no_req"}, seen, 0);
        chk({tag, "_no_ack"}, ack_cnt - a0, 0);
    endtask

    function automatic int count_writes(input logic [AW-1:0] a, input bit any);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][AW+WW] && (any || obs_q[i][AW+WW-1:WW] == a)) n++;
        return n;
    endfunction

    initial begin : main
        bit seen;
        int a0;
        bus.lc_req = 1'b0; bus.lc_data = '0;

        // Requests before enable are ignored.
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1; bus.lc_req = 1'b1; seen = 1'b0;
        repeat (5) begin @(negedge clk_i); #1; if (bus.otp_req) seen = 1'b1; end
        bus.lc_req = 1'b0;
        chk("resetst_req_ignored", seen, 0);

        // Zero-word skipping.
        do_reset();
        img[0] = 16'h0001; img[1] = 16'h0000; img[2] = 16'h8000; img[3] = 16'h00FF;
        run_txn("skip");
        chk("skip_writes", count_writes('0, 1'b1), 3);
        chk("skip_no_w1", count_writes(AW'('h171), 1'b0), 0);

        // Two MacroErrors on word 0 are absorbed by retries.
        do_reset();
        plan = '{1, 1, 0};
        run_txn("retry_ok");
        chk("retry_ok_w0_writes", count_writes(AW'('h170), 1'b0), 3);

        // Retries exhausted on word 1: remaining words still programmed, terminal error.
        do_reset();
        img[0] = 16'h0001; img[1] = 16'h0002; img[2] = 16'h0003; img[3] = 16'h0004;
        plan = '{0, 1, 1, 1, 0, 0};
        run_txn("retry_fail");
        chk("retry_fail_error_o", error_o, 1);
        chk("retry_fail_w3_written", count_writes(AW'('h173), 1'b0), 1);
        chk_locked("retry_fail");

        // Non-retryable code on word 2.
        do_reset();
        plan = '{0, 0, 4, 0};
        run_txn("code4");
        chk("code4_error_o", error_o, 4);
        chk("code4_w3_written", count_writes(AW'('h173), 1'b0), 1);

`ifdef OTP_LCI_READBACK_EN
        // Read-back returns zeros: CheckFailError after retries.
        do_reset();
        force_zero = 1'b1;
        run_txn("readback");
        chk("readback_error_o", error_o, 6);
`endif

        // Escalation while a write response is outstanding.
        do_reset();
        hold = 4; a0 = ack_cnt;
        load_image();
        bus.lc_req = 1'b1; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i); #3;
            if (obs_q.size() > 0) begin seen = 1'b1; break; end
        end
        bus.lc_req = 1'b0;
        chk("esc_grant_seen", seen, 1);
        @(negedge clk_i);
        escalate = 1'b1;
        #1 chk("esc_fsm_err", fsm_err_o, 1);
        @(negedge clk_i);
        escalate = 1'b0;
        #1;
        chk("esc_error_o", error_o, 7);
        chk("esc_not_idle", idle_o, 0);
        chk("esc_fsm_err_drop", fsm_err_o, 0);
        repeat (8) @(negedge clk_i);
        chk("esc_no_ack", ack_cnt - a0, 0);
        chk_locked("esc");

        // Randomized images and response codes.
        for (int t = 0; t < 25; t++) begin
            int r;
            do_reset();
            for (int i = 0; i < int'(NW); i++)
                img[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            for (int i = 0; i < 24; i++) begin
                r = $urandom_range(0, 9);
                plan.push_back((r < 6) ? 0 : (r < 8) ? 1 : $urandom_range(2, 5));
            end
            run_txn("rand");
            if (exp_err != 0) chk_locked("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
